// File: rtl/writeback_stage.sv
// Final RISC-V pipeline stage: selects ALU / load / PC+4 result, waits on the
// data-memory response for loads, drives the register-file write port.
module writeback_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic [1:0]       in_wbsel,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_pc4,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             writecmd,
    output logic [4:0]       writeReg,
    output logic [31:0]      wback,
    output logic             load_fault,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_rd, w_rd_nxt;
    logic             r_regwrite, w_regwrite_nxt;
    logic [2:0]       r_funct3, w_funct3_nxt;
    logic [1:0]       r_addr_lo, w_addr_lo_nxt;
    logic [TW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_writecmd, w_writecmd_nxt;
    logic [4:0]       r_write_reg, w_write_reg_nxt;
    logic [31:0]      r_wback, w_wback_nxt;
    logic             r_load_fault, w_load_fault_nxt;
    logic [CNT_W-1:0] r_retired, w_retired_nxt;
    logic             w_accept;

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = d;
        endcase
        return res;
    endfunction

    assign in_ready   = (r_state != WAIT_MEM);
    assign w_accept   = in_valid && in_ready;
    assign writecmd   = r_writecmd;
    assign writeReg   = r_write_reg;
    assign wback      = r_wback;
    assign load_fault = r_load_fault;
    assign retired    = r_retired;

    // Next-state and next-output decode; writeReg/wback hold unless a write fires.
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_nxt         = r_rd;
        w_regwrite_nxt   = r_regwrite;
        w_funct3_nxt     = r_funct3;
        w_addr_lo_nxt    = r_addr_lo;
        w_cnt_nxt        = r_cnt;
        w_writecmd_nxt   = 1'b0;
        w_write_reg_nxt  = r_write_reg;
        w_wback_nxt      = r_wback;
        w_load_fault_nxt = 1'b0;
        w_retired_nxt    = r_retired;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_wbsel == 2'b01) begin
                        w_rd_nxt       = in_rd;
                        w_regwrite_nxt = in_regwrite;
                        w_funct3_nxt   = in_funct3;
                        w_addr_lo_nxt  = in_addr_lo;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = WAIT_MEM;
                    end else begin
                        w_retired_nxt = r_retired + CNT_W'(1);
                        if (in_regwrite && (in_rd != 5'd0)) begin
                            w_writecmd_nxt  = 1'b1;
                            w_write_reg_nxt = in_rd;
                            w_wback_nxt     = (in_wbsel == 2'b10) ? in_pc4 : in_alu;
                        end else begin
                            w_writecmd_nxt = 1'b0;
                        end
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                // Data arriving on the final counted cycle still wins over the timeout.
                if (mem_rvalid) begin
                    w_state_nxt   = IDLE;
                    w_retired_nxt = r_retired + CNT_W'(1);
                    if (r_regwrite && (r_rd != 5'd0)) begin
                        w_writecmd_nxt  = 1'b1;
                        w_write_reg_nxt = r_rd;
                        w_wback_nxt     = load_extend(r_funct3, r_addr_lo, mem_rdata);
                    end else begin
                        w_writecmd_nxt = 1'b0;
                    end
                end else if (r_cnt == T_LAST) begin
                    w_load_fault_nxt = 1'b1;
                    w_state_nxt      = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, latched load context and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rd         <= 5'd0;
            r_regwrite   <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_cnt        <= '0;
            r_writecmd   <= 1'b0;
            r_write_reg  <= 5'd0;
            r_wback      <= 32'd0;
            r_load_fault <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd         <= w_rd_nxt;
            r_regwrite   <= w_regwrite_nxt;
            r_funct3     <= w_funct3_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            r_cnt        <= w_cnt_nxt;
            r_writecmd   <= w_writecmd_nxt;
            r_write_reg  <= w_write_reg_nxt;
            r_wback      <= w_wback_nxt;
            r_load_fault <= w_load_fault_nxt;
            r_retired    <= w_retired_nxt;
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RISC-V core; drives the register-file write port that the decode stage reads from.
- Accepts retiring instructions from the memory stage and selects the result: ALU result, load data, or PC+4.
- Waits on the data-memory response for loads and sign- or zero-extends the loaded value.
- Issues exactly one registered write per instruction, suppresses writes to x0, and counts retired instructions.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_rvalid before abandoning a load (must be ≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_rd  input  5  destination register index
- in_regwrite  input  1  instruction writes rd
- in_wbsel  input  2  00 ALU, 01 MEM, 10 PC+4, 11 reserved (treated as ALU)
- in_funct3  input  3  load width/sign (valid when in_wbsel=01)
- in_addr_lo  input  2  byte offset of load address
- in_alu  input  32  ALU result
- in_pc4  input  32  PC+4
- mem_rvalid  input  1  load data valid (single-cycle pulse)
- mem_rdata  input  32  load data word (aligned)
- writecmd  output  1  register-file write enable
- writeReg  output  5  register-file write index
- wback  output  32  register-file write data
- load_fault  output  1  one-cycle pulse: load timed out
- retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - writecmd=0, writeReg=0, wback=0, load_fault=0, retired=0.
  - in_ready=1 once rst deasserts.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state != WAIT_MEM); combinational from state only.
- States: IDLE, WAIT_MEM.
- IDLE, accept with wbsel≠01:
  - Next cycle: writecmd = in_regwrite && (in_rd≠0); writeReg=in_rd; wback = in_pc4 if wbsel=10, else in_alu.
  - retired increments by 1.
  - Latency 1 cycle; back-to-back accepts give one write per cycle.
- IDLE, accept with wbsel=01:
  - Latch rd, regwrite, funct3, addr_lo; go to WAIT_MEM; timeout counter=0.
  - writecmd=0 next cycle.
- WAIT_MEM:
  - mem_rvalid=1: next cycle writecmd = latched regwrite && rd≠0, wback = extended data, retired+1, state→IDLE. in_ready is 1 in that commit cycle, so a new instruction may be accepted then.
  - No mem_rvalid: counter increments. When counter reaches TIMEOUT-1 without rvalid, the next cycle pulses load_fault=1 and returns to IDLE; no write; retired unchanged.
  - mem_rvalid on the same cycle the counter hits TIMEOUT-1: data wins, no fault.
- Load extension (byte b = mem_rdata[8*addr_lo +: 8]; half h = mem_rdata[16*addr_lo[1] +: 16], addr_lo[0] ignored):
  - 000 LB → sign-extend b.
  - 001 LH → sign-extend h.
  - 010 LW → full word.
  - 100 LBU → zero-extend b.
  - 101 LHU → zero-extend h.
  - 011/110/111 → full word.
- Outputs:
  - writecmd and load_fault are high for exactly one cycle per event, otherwise 0.
  - writeReg/wback hold their last values when writecmd=0.
- mem_rvalid outside WAIT_MEM is ignored.
- retired wraps modulo 2^CNT_W.
- rd=0 instructions still count as retired (including loads to x0 that complete).
- rst asserted mid-load: immediately back to IDLE, pending load discarded, all outputs at reset values.

Test Plan:
- Reset, then ALU op: rd=5, regwrite=1, wbsel=00, alu=0x0000_1234 → next cycle writecmd=1, writeReg=5, wback=0x1234, retired=1.
- Back-to-back ALU ops to rd=1,2,3 on consecutive cycles → three consecutive writecmd pulses with matching data, in_ready held 1, retired=3.
- LB: addr_lo=2, rdata=0x0080_0000, rvalid 3 cycles after accept → in_ready=0 for 3 cycles, then wback=0xFFFF_FF80. LBU on the same data → 0x0000_0080. LH with addr_lo=2, rdata=0x8001_0000 → 0xFFFF_8001.
- x0 and PC+4: JAL rd=0, wbsel=10 → writecmd=0, retired+1. JAL rd=1, pc4=0x0000_0104 → wback=0x104.
- Timeout with TIMEOUT=4: load accepted, no rvalid → load_fault pulses 4 cycles after accept, no writecmd, retired unchanged, in_ready=1 again. A stray rvalid afterwards → ignored.
- Async reset mid-load: assert rst between clock edges during WAIT_MEM → outputs zero immediately. After release, rvalid → no write, in_ready=1.
